video_decode: RTL and testbench



---
 rtl/video_pkg.sv | 31 +++
 rtl/video_decode_fifo.sv | 54 +++++
 rtl/video_decode.sv | 118 +++++++++++
 tb/tb_video_decode.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and the DAC-word decode used by the video_decode block and its FIFO.
package video_pkg;

   localparam int LINE_CLKS = 384;

   typedef struct packed {
      logic [15:0] pc;
      logic        shadow;
      logic [8:0]  x;
      logic [8:0]  y;
      logic        eol;
   } px_t;

   localparam int PX_W = $bits(px_t);

   typedef struct packed {
      logic [15:0] pc;
      logic        shadow;
      logic        mismatch;
   } dec_t;

   // R carries the authoritative SHADOW and PC[15]; G and B copies only feed the mismatch flag.
   function automatic dec_t pc_decode(input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
      dec_t d;
      d.pc       = {r[0], r[1], g[1], b[1], r[5:2], g[5:2], b[5:2]};
      d.shadow   = r[6];
      d.mismatch = (g[6] != r[6]) || (b[6] != r[6]) || (g[0] != r[0]) || (b[0] != r[0]);
      return d;
   endfunction

endpackage

// File: rtl/video_decode_fifo.sv
// Power-of-two pixel FIFO; head is read straight from the storage registers.
module video_decode_fifo
   import video_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_push,
   input  logic [PX_W-1:0] i_data,
   input  logic            i_pop,
   output logic [PX_W-1:0] o_head,
   output logic            o_full,
   output logic            o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

   logic [PX_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]   r_wr;
   logic [AW-1:0]   r_rd;
   logic [AW:0]     r_cnt;
   logic            w_do_push;
   logic            w_do_pop;

   assign o_full    = (r_cnt == CNT_FULL);
   assign o_empty   = (r_cnt == '0);
   assign o_head    = r_mem[r_rd];
   assign w_do_pop  = i_pop && !o_empty;
   // When full, a same-cycle pop frees the head slot that the write pointer targets.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_do_pop) r_rd <= r_rd + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/video_decode.sv
// Rebuilds palette words from the registered DAC outputs and streams tagged pixels out.
module video_decode
   import video_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int VBL_MIN    = 400
) (
   input  logic        CLK_6MB,
   input  logic        RESET,
   input  logic        nBNKB,
   input  logic [6:0]  VIDEO_R,
   input  logic [6:0]  VIDEO_G,
   input  logic [6:0]  VIDEO_B,
   output logic        PX_VALID,
   input  logic        PX_READY,
   output logic [15:0] PX_DATA,
   output logic        PX_SHADOW,
   output logic [8:0]  PX_X,
   output logic [8:0]  PX_Y,
   output logic        PX_EOL,
   output logic        ERR_ENC,
   output logic        ERR_OVF
);

   // PX_VALID/PX_READY: a pixel transfers on a rising edge where both are high; until then
   // PX_VALID stays high and the head fields hold steady. PX_VALID never depends on PX_READY.

   localparam int RUN_W = $clog2(VBL_MIN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(VBL_MIN);

   logic             r_bnk_d;
   logic             r_primed;
   logic             r_armed;
   logic             r_skid_vld;
   px_t              r_skid;
   logic [8:0]       r_x;
   logic [8:0]       r_y;
   logic [RUN_W-1:0] r_run;
   logic             r_err_enc;
   logic             r_err_ovf;

   dec_t w_dec;
   logic w_active;
   logic w_blank;
   logic w_full;
   logic w_empty;
   px_t  w_push_px;
   px_t  w_head;

   always_comb begin
      w_dec     = pc_decode(VIDEO_R, VIDEO_G, VIDEO_B);
      // r_primed ignores the stale bnk_d level left over from reset.
      w_active  = r_primed && r_bnk_d;
      w_blank   = r_primed && !r_bnk_d;
      w_push_px = r_skid;
      w_push_px.eol = !r_bnk_d;
   end

   always_ff @(posedge CLK_6MB or posedge RESET) begin
      if (RESET) begin
         r_bnk_d    <= 1'b0;
         r_primed   <= 1'b0;
         r_armed    <= 1'b0;
         r_skid_vld <= 1'b0;
         r_skid     <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_run      <= '0;
         r_err_enc  <= 1'b0;
         r_err_ovf  <= 1'b0;
      end else begin
         r_bnk_d  <= nBNKB;
         r_primed <= 1'b1;
         if (w_blank) begin
            r_armed    <= 1'b1;
            r_x        <= '0;
            r_skid_vld <= 1'b0;
            if (|{VIDEO_R, VIDEO_G, VIDEO_B}) r_err_enc <= 1'b1;
            if (r_run != RUN_MAX) r_run <= r_run + 1'b1;
            if (r_run >= RUN_MAX - 1'b1) r_y <= '0;
            else if (r_skid_vld)         r_y <= r_y + 9'd1;
         end else if (w_active) begin
            r_run <= '0;
            if (w_dec.mismatch) r_err_enc <= 1'b1;
            // Mid-line samples after reset are dropped until a real blank arms the line.
            if (r_armed) begin
               r_skid_vld <= 1'b1;
               r_skid     <= '{pc: w_dec.pc, shadow: w_dec.shadow, x: r_x, y: r_y, eol: 1'b0};
               if (r_x != 9'd511) r_x <= r_x + 9'd1;
            end
         end
         if (r_skid_vld && w_full && !PX_READY) r_err_ovf <= 1'b1;
      end
   end

   video_decode_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (CLK_6MB),
      .i_rst   (RESET),
      .i_push  (r_skid_vld),
      .i_data  (w_push_px),
      .i_pop   (PX_READY),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign PX_VALID  = !w_empty;
   assign PX_DATA   = w_head.pc;
   assign PX_SHADOW = w_head.shadow;
   assign PX_X      = w_head.x;
   assign PX_Y      = w_head.y;
   assign PX_EOL    = w_head.eol;
   assign ERR_ENC   = r_err_enc;
   assign ERR_OVF   = r_err_ovf;

endmodule

// File: tb/tb_video_decode.sv
// Drives line/blank sequences like the video output stage and checks the pixel stream
// against a line-level model of which pixels should come out and with what tags.
module tb_video_decode;
   import video_pkg::*;

   localparam int FIFO_DEPTH = 4;
   localparam int VBL_MIN    = 400;

   logic        CLK_6MB;
   logic        RESET;
   logic        nBNKB;
   logic [6:0]  VIDEO_R, VIDEO_G, VIDEO_B;
   logic        PX_VALID, PX_READY;
   logic [15:0] PX_DATA;
   logic        PX_SHADOW;
   logic [8:0]  PX_X, PX_Y;
   logic        PX_EOL, ERR_ENC, ERR_OVF;

   video_decode #(.FIFO_DEPTH(FIFO_DEPTH), .VBL_MIN(VBL_MIN)) dut (
      .CLK_6MB(CLK_6MB), .RESET(RESET), .nBNKB(nBNKB),
      .VIDEO_R(VIDEO_R), .VIDEO_G(VIDEO_G), .VIDEO_B(VIDEO_B),
      .PX_VALID(PX_VALID), .PX_READY(PX_READY), .PX_DATA(PX_DATA),
      .PX_SHADOW(PX_SHADOW), .PX_X(PX_X), .PX_Y(PX_Y), .PX_EOL(PX_EOL),
      .ERR_ENC(ERR_ENC), .ERR_OVF(ERR_OVF)
   );

   // ---------------- clock / reset ----------------
   initial begin
      CLK_6MB = 1'b0;
      forever #5 CLK_6MB = ~CLK_6MB;
   end

   // ---------------- scoreboard state ----------------
   logic [35:0] exp_q[$];     // {pc, shadow, x, y, eol}
   int          n_checks = 0;
   int          n_errors = 0;
   logic        exp_enc  = 1'b0;
   logic        exp_ovf  = 1'b0;
   int          m_y      = 0;
   int          m_run    = 0;
   bit          m_armed  = 1'b0;
   bit          m_stall  = 1'b0;
   int          ready_mode = 0;   // 0 always ready, 1 random, 2 held low
   logic [20:0] pend_rgb = '0;

   task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Forward mapping from palette word to the three DAC words.
   function automatic logic [20:0] encode(input logic [15:0] pc, input logic sh);
      return {sh, pc[11:8], pc[14], pc[15], sh, pc[7:4], pc[13], pc[15], sh, pc[3:0], pc[12], pc[15]};
   endfunction

   // ---------------- driver tasks ----------------
   // The output stage presents RGB one clock after its nBNKB, and zero while blanked.
   task automatic drive_slot(input logic act, input logic [20:0] rgb);
      @(posedge CLK_6MB);
      #1;
      nBNKB = act;
      {VIDEO_R, VIDEO_G, VIDEO_B} = pend_rgb;
      pend_rgb = act ? rgb : 21'd0;
   endtask

   task automatic send_blank(input int n);
      for (int i = 0; i < n; i++) begin
         drive_slot(1'b0, 21'd0);
         m_armed = 1'b1;
         m_run++;
         if (m_run >= VBL_MIN) m_y = 0;
      end
   endtask

   task automatic model_px(input logic [15:0] pc, input logic sh, input int i, input bit last);
      logic [8:0] x;
      x = (i > 511) ? 9'd511 : 9'(i);
      if (m_stall && exp_q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back({pc, sh, x, 9'(m_y), last});
   endtask

   task automatic do_reset();
      #1 RESET = 1'b1;
      exp_q.delete();
      m_armed = 1'b0;
      m_y     = 0;
      m_run   = 0;
      exp_enc = 1'b0;
      exp_ovf = 1'b0;
      @(negedge CLK_6MB);
      check_val("rst_valid", 40'(PX_VALID), 40'd0);
      check_val("rst_err", 40'({ERR_ENC, ERR_OVF}), 40'd0);
      @(posedge CLK_6MB);
      #1 RESET = 1'b0;
   endtask

   // mode: 0 random, 1 0xFFFF/sh0, 2 0x8123/sh1, 3 bad encoding on first pixel then random
   task automatic send_line(input int n, input int mode, input int rst_at);
      bit line_ok;
      line_ok = m_armed;
      m_run = 0;
      for (int i = 0; i < n; i++) begin
         logic [15:0] pc;
         logic        sh;
         logic [20:0] rgb;
         pc = 16'($urandom);
         sh = 1'($urandom_range(0, 1));
         if (mode == 1) begin pc = 16'hFFFF; sh = 1'b0; end
         if (mode == 2) begin pc = 16'h8123; sh = 1'b1; end
         rgb = encode(pc, sh);
         if (mode == 3 && i == 0) begin
            rgb = {7'h01, 7'h00, 7'h00};
            pc  = 16'h8000;
            sh  = 1'b0;
            exp_enc = 1'b1;
         end
         drive_slot(1'b1, rgb);
         if (line_ok) model_px(pc, sh, i, i == n - 1);
         if (i == rst_at) begin
            do_reset();
            line_ok = 1'b0;
         end
      end
      if (line_ok) m_y++;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         send_blank(1);
         n++;
      end
      send_blank(3);
      check_val("drain_left", 40'(exp_q.size()), 40'd0);
   endtask

   // ---------------- consumer ----------------
   initial begin
      PX_READY = 1'b1;
      forever begin
         @(posedge CLK_6MB);
         #1;
         case (ready_mode)
            0:       PX_READY = 1'b1;
            1:       PX_READY = 1'($urandom_range(0, 1));
            default: PX_READY = 1'b0;
         endcase
      end
   end

   initial begin
      logic [35:0] e;
      forever begin
         @(negedge CLK_6MB);
         if (PX_VALID === 1'b1 && PX_READY === 1'b1 && RESET === 1'b0) begin
            if (exp_q.size() == 0) begin
               check_val("unexpected_px", 40'({PX_DATA, PX_SHADOW, PX_X, PX_Y, PX_EOL}), 40'hFF_FFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check_val("px", 40'({PX_DATA, PX_SHADOW, PX_X, PX_Y, PX_EOL}), 40'(e));
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      RESET = 1'b1;
      nBNKB = 1'b0;
      {VIDEO_R, VIDEO_G, VIDEO_B} = 21'd0;
      repeat (3) @(posedge CLK_6MB);
      @(negedge CLK_6MB);
      check_val("rst_px_valid", 40'(PX_VALID), 40'd0);
      check_val("rst_px_data", 40'(PX_DATA), 40'd0);
      check_val("rst_px_shadow", 40'(PX_SHADOW), 40'd0);
      check_val("rst_px_x", 40'(PX_X), 40'd0);
      check_val("rst_px_y", 40'(PX_Y), 40'd0);
      check_val("rst_px_eol", 40'(PX_EOL), 40'd0);
      check_val("rst_err_enc", 40'(ERR_ENC), 40'd0);
      check_val("rst_err_ovf", 40'(ERR_OVF), 40'd0);
      @(posedge CLK_6MB);
      #1 RESET = 1'b0;
      send_blank(10);

      send_line(3, 1, -1);
      send_blank(10);
      wait_drain();
      check_val("enc_clean", 40'(ERR_ENC), 40'(exp_enc));

      send_line(2, 2, -1);
      send_blank(10);
      wait_drain();

      send_line(3, 3, -1);
      send_blank(10);
      wait_drain();
      check_val("enc_set", 40'(ERR_ENC), 40'(exp_enc));
      send_line(5, 0, -1);
      send_blank(10);
      wait_drain();
      check_val("enc_sticky", 40'(ERR_ENC), 40'(exp_enc));

      // Frame structure: a VBL run, two lines with a short gap, another VBL run, one line.
      send_blank(VBL_MIN);
      send_line(320, 0, -1);
      send_blank(LINE_CLKS - 320);
      send_line(320, 0, -1);
      send_blank(VBL_MIN);
      send_line(320, 0, -1);
      send_blank(10);
      wait_drain();

      // Consumer stalled through a whole line.
      ready_mode = 2;
      m_stall    = 1'b1;
      send_line(10, 0, -1);
      send_blank(8);
      check_val("ovf_set", 40'(ERR_OVF), 40'(exp_ovf));
      m_stall    = 1'b0;
      ready_mode = 0;
      wait_drain();

      // X saturation on an over-long line.
      send_line(520, 0, -1);
      send_blank(10);
      wait_drain();

      ready_mode = 1;
      for (int k = 0; k < 12; k++) begin
         send_line($urandom_range(1, 4), 0, -1);
         send_blank($urandom_range(5, 20));
         wait_drain();
      end
      ready_mode = 0;
      check_val("ovf_sticky", 40'(ERR_OVF), 40'(exp_ovf));
      check_val("enc_sticky2", 40'(ERR_ENC), 40'(exp_enc));

      // Reset in the middle of a line: the remainder of that line must not appear.
      send_blank(10);
      send_line(200, 0, 100);
      send_blank(12);
      send_line(5, 0, -1);
      send_blank(10);
      wait_drain();
      check_val("post_rst_enc", 40'(ERR_ENC), 40'(exp_enc));
      check_val("post_rst_ovf", 40'(ERR_OVF), 40'(exp_ovf));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
